// File: rtl/uart_fifo_n.sv
// rtl/uart_fifo_n.sv - Full-duplex UART with TX/RX FIFOs, parity, stop bits, sticky RX errors; optional UART_LOOPBACK_EN adds a loopback port

// Synchronous FIFO, first-word-fall-through head, pointers one bit wider than the address
module uart_fifo_n_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rptr[aw-1:0]];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[aw-1:0]] <= push_data;
        end
    end

    // Read and write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + {{aw{1'b0}}, 1'b1};
            if (pop_ok)  rptr <= rptr + {{aw{1'b0}}, 1'b1};
        end
    end
endmodule

module uart_fifo_n #(
    parameter int clk_reduction = 64,
    parameter int word_width    = 8,
    parameter int fifo_depth    = 8,
    parameter int stop_bits     = 1,
    parameter int parity_mode   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [word_width-1:0] T_W,
    output logic                  T_full,
    output logic                  T_busy,
    input  logic                  read,
    output logic [word_width-1:0] R_W,
    output logic                  R_empty,
    output logic                  R_overrun,
    output logic                  R_frame_err,
    output logic                  R_parity_err,
    input  logic                  clear_err,
`ifdef UART_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  RX,
    output logic                  TX
);
    localparam int cw = $clog2(clk_reduction);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic lb;
`ifdef UART_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    // ---------------- TX path ----------------
    logic [word_width-1:0] tf_head;
    logic                  tf_full;
    logic                  tf_empty;
    logic                  tf_pop;

    uart_fifo_n_fifo #(.width(word_width), .depth(fifo_depth)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (write),
        .push_data (T_W),
        .pop       (tf_pop),
        .head      (tf_head),
        .full      (tf_full),
        .empty     (tf_empty)
    );

    state_t                tx_state;
    state_t                tx_state_nxt;
    logic [cw-1:0]         tx_cnt;
    logic [3:0]            tx_bit;
    logic [word_width-1:0] tx_shift;
    logic                  tx_par;
    logic                  tx_q;
    logic                  tx_line_nxt;
    logic                  tx_tick;

    assign tx_tick = (tx_cnt == cw'(clk_reduction - 1));

    // TX next-state: the word stays in the FIFO until the start bit has been sent
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            S_IDLE:   if (!tf_empty) tx_state_nxt = S_START;
            S_START:  if (tx_tick) tx_state_nxt = S_DATA;
            S_DATA:   if (tx_tick && tx_bit == 4'(word_width - 1))
                          tx_state_nxt = (parity_mode != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tick) tx_state_nxt = S_STOP;
            S_STOP:   if (tx_tick && tx_bit == 4'(stop_bits - 1))
                          tx_state_nxt = tf_empty ? S_IDLE : S_START;
            default:  tx_state_nxt = S_IDLE;
        endcase
    end

    // TX outputs: pop at the end of the start bit, line level for the current state
    always_comb begin
        tf_pop      = (tx_state == S_START) && tx_tick;
        tx_line_nxt = 1'b1;
        case (tx_state)
            S_START:  tx_line_nxt = 1'b0;
            S_DATA:   tx_line_nxt = tx_shift[0];
            S_PARITY: tx_line_nxt = tx_par;
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    // TX state register, bit divider, shift register and registered line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_q     <= tx_line_nxt;
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + 1'b1;
            if (tx_state_nxt != tx_state) tx_bit <= '0;
            else if (tx_tick)             tx_bit <= tx_bit + 4'd1;
            if (tf_pop) begin
                tx_shift <= tf_head;
                tx_par   <= (parity_mode == 2) ? ~^tf_head : ^tf_head;
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    assign TX     = lb ? 1'b1 : tx_q;
    assign T_full = tf_full;
    assign T_busy = (tx_state != S_IDLE) || !tf_empty;

    // ---------------- RX path ----------------
    logic                  rx_in;
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    state_t                rx_state;
    state_t                rx_state_nxt;
    logic [cw-1:0]         rx_cnt;
    logic [3:0]            rx_bit;
    logic [word_width-1:0] rx_shift;
    logic                  rx_par;
    logic                  rx_tick;
    logic                  stop_sample;
    logic                  par_bad;
    logic                  set_frame;
    logic                  set_par;
    logic                  set_ovr;
    logic                  rf_push;
    logic [word_width-1:0] rf_head;
    logic                  rf_full;
    logic                  rf_empty;

    assign rx_in = lb ? tx_q : RX;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Start bit is sampled after half a bit, everything else after a full bit
    assign rx_tick = (rx_state == S_START) ? (rx_cnt == cw'(clk_reduction / 2 - 1))
                                           : (rx_cnt == cw'(clk_reduction - 1));

    // RX next-state: a high start sample is a glitch; the stop sample ends the frame at once
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_prev && !rx_sync) rx_state_nxt = S_START;
            S_START:  if (rx_tick) rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tick && rx_bit == 4'(word_width - 1))
                          rx_state_nxt = (parity_mode != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (rx_tick) rx_state_nxt = S_STOP;
            S_STOP:   if (rx_tick) rx_state_nxt = S_IDLE;
            default:  rx_state_nxt = S_IDLE;
        endcase
    end

    // RX outputs: frame verdict at the stop sample
    always_comb begin
        stop_sample = (rx_state == S_STOP) && rx_tick;
        par_bad     = (parity_mode != 0) &&
                      (rx_par != ((parity_mode == 2) ? ~^rx_shift : ^rx_shift));
        set_frame   = stop_sample && !rx_sync;
        set_par     = stop_sample && rx_sync && par_bad;
        rf_push     = stop_sample && rx_sync && !par_bad && !rf_full;
        set_ovr     = stop_sample && rx_sync && !par_bad && rf_full;
    end

    // RX state register, divider and data/parity capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
            else                               rx_cnt <= rx_cnt + 1'b1;
            if (rx_state_nxt != rx_state) rx_bit <= '0;
            else if (rx_tick)             rx_bit <= rx_bit + 4'd1;
            if (rx_state == S_DATA && rx_tick)   rx_shift <= {rx_sync, rx_shift[word_width-1:1]};
            if (rx_state == S_PARITY && rx_tick) rx_par   <= rx_sync;
        end
    end

    uart_fifo_n_fifo #(.width(word_width), .depth(fifo_depth)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rf_push),
        .push_data (rx_shift),
        .pop       (read),
        .head      (rf_head),
        .full      (rf_full),
        .empty     (rf_empty)
    );

    // Sticky error flags; a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_overrun    <= 1'b0;
            R_frame_err  <= 1'b0;
            R_parity_err <= 1'b0;
        end else begin
            R_overrun    <= set_ovr   || (R_overrun    && !clear_err);
            R_frame_err  <= set_frame || (R_frame_err  && !clear_err);
            R_parity_err <= set_par   || (R_parity_err && !clear_err);
        end
    end

    assign R_empty = rf_empty;
    assign R_W     = rf_empty ? '0 : rf_head;
endmodule
